// File: rtl/dual_dmem_stq_if.sv
// Lane bus for the dual-issue data-memory stage: two store/load lanes plus
// store-queue status back to the hazard logic.
interface dual_dmem_stq_if #(
    parameter int unsigned STQ_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(STQ_DEPTH) + 1;

    logic             a_memwriteM;
    logic [31:0]      a_aluoutM;
    logic [31:0]      a_writedataM;
    logic             b_memwriteM;
    logic [31:0]      b_aluoutM;
    logic [31:0]      b_writedataM;
    logic [31:0]      a_readdataM;
    logic [31:0]      b_readdataM;
    logic             stq_full;
    logic [CNT_W-1:0] stq_count;
    logic             stq_overflow;

    modport master (
        output a_memwriteM, a_aluoutM, a_writedataM,
        output b_memwriteM, b_aluoutM, b_writedataM,
        input  a_readdataM, b_readdataM,
        input  stq_full, stq_count, stq_overflow
    );

    modport slave (
        input  a_memwriteM, a_aluoutM, a_writedataM,
        input  b_memwriteM, b_aluoutM, b_writedataM,
        output a_readdataM, b_readdataM,
        output stq_full, stq_count, stq_overflow
    );
endinterface

// File: rtl/dual_dmem_stq.sv
// Dual-lane data memory: in-order store queue draining one word per cycle
// into a single-write-port array, with store-to-load forwarding on both lanes.
module dual_dmem_stq #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned STQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    dual_dmem_stq_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(STQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WORDS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] idx_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } fwd_t;

    // Queue state; valid/pointers are reset, payload is not.
    logic [STQ_DEPTH-1:0] q_valid;
    idx_t                 q_idx  [STQ_DEPTH];
    logic [31:0]          q_data [STQ_DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 overflow;

    logic [31:0]          mem [WORDS];

    idx_t             a_idx_c;
    idx_t             b_idx_c;
    logic             drain_c;
    logic             acc_a_c;
    logic             acc_b_c;
    logic             drop_c;
    logic [CNT_W-1:0] free_c;
    logic [CNT_W-1:0] count_next_c;
    logic [PTR_W-1:0] tail_b_c;
    fwd_t             a_fwd_c;
    fwd_t             b_fwd_c;
    logic [31:0]      a_rd_c;
    logic [31:0]      b_rd_c;

    assign a_idx_c = bus.a_aluoutM[ADDR_W+1:2];
    assign b_idx_c = bus.b_aluoutM[ADDR_W+1:2];

    // Byte offset and high address bits do not select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.a_aluoutM[31:ADDR_W+2], bus.a_aluoutM[1:0],
                                bus.b_aluoutM[31:ADDR_W+2], bus.b_aluoutM[1:0]};

    // Drain frees its slot before enqueue; lane b is the first to be dropped.
    always_comb begin
        drain_c      = (count != '0);
        free_c       = CNT_W'(STQ_DEPTH) - count + CNT_W'(drain_c);
        acc_a_c      = bus.a_memwriteM && (free_c != '0);
        acc_b_c      = bus.b_memwriteM && (free_c > CNT_W'(acc_a_c));
        drop_c       = (bus.a_memwriteM && !acc_a_c) || (bus.b_memwriteM && !acc_b_c);
        count_next_c = count - CNT_W'(drain_c) + CNT_W'(acc_a_c) + CNT_W'(acc_b_c);
        tail_b_c     = tail + PTR_W'(acc_a_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            q_valid  <= '0;
        end else begin
            // Enqueue assignments come last so a slot reused in the drain cycle stays valid.
            if (drain_c) begin
                q_valid[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (acc_a_c) q_valid[tail]     <= 1'b1;
            if (acc_b_c) q_valid[tail_b_c] <= 1'b1;
            tail     <= tail + PTR_W'(acc_a_c) + PTR_W'(acc_b_c);
            count    <= count_next_c;
            full     <= (count_next_c > CNT_W'(STQ_DEPTH - 2));
            if (drop_c) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_a_c) begin
            q_idx[tail]  <= a_idx_c;
            q_data[tail] <= bus.a_writedataM;
        end
        if (acc_b_c) begin
            q_idx[tail_b_c]  <= b_idx_c;
            q_data[tail_b_c] <= bus.b_writedataM;
        end
    end

    // Single write port; count is cleared asynchronously so reset blocks the drain.
    always_ff @(posedge clk) begin
        if (drain_c) mem[q_idx[head]] <= q_data[head];
    end

    // Walks oldest to youngest so the last hit is the youngest matching store.
    function automatic fwd_t fwd_lookup(input idx_t idx);
        fwd_t             r;
        logic [PTR_W-1:0] slot;
        r = '0;
        for (int unsigned i = 0; i < STQ_DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if (q_valid[slot] && (q_idx[slot] == idx)) begin
                r.hit  = 1'b1;
                r.data = q_data[slot];
            end
        end
        return r;
    endfunction

    always_comb begin
        a_fwd_c = fwd_lookup(a_idx_c);
        b_fwd_c = fwd_lookup(b_idx_c);
        a_rd_c  = a_fwd_c.hit ? a_fwd_c.data : mem[a_idx_c];
        if (bus.a_memwriteM && (a_idx_c == b_idx_c)) begin
            b_rd_c = bus.a_writedataM;
        end else if (b_fwd_c.hit) begin
            b_rd_c = b_fwd_c.data;
        end else begin
            b_rd_c = mem[b_idx_c];
        end
    end

    assign bus.a_readdataM  = a_rd_c;
    assign bus.b_readdataM  = b_rd_c;
    assign bus.stq_full     = full;
    assign bus.stq_count    = count;
    assign bus.stq_overflow = overflow;

endmodule

// File: tb/tb_dual_dmem_stq.sv
// Directed bench for dual_dmem_stq: forwarding, drain ordering, overflow,
// stalling with pointer wrap, and reset with stores pending.
module tb_dual_dmem_stq;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned STQ_DEPTH = 4;
    localparam int unsigned CNT_W     = $clog2(STQ_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dual_dmem_stq_if #(.STQ_DEPTH(STQ_DEPTH)) bus ();

    dual_dmem_stq #(.ADDR_W(ADDR_W), .STQ_DEPTH(STQ_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic drive(input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                         input logic bw, input logic [31:0] ba, input logic [31:0] bd);
        bus.a_memwriteM  = aw;
        bus.a_aluoutM    = aa;
        bus.a_writedataM = ad;
        bus.b_memwriteM  = bw;
        bus.b_aluoutM    = ba;
        bus.b_writedataM = bd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store_and_drain(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, addr, data, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while (bus.stq_count != '0 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (bus.stq_count !== '0) begin
            n_fail++;
            $display("FAIL %s drain timeout: count=%0d required 0", name, bus.stq_count);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.stq_count); end
        n_tests++; if (bus.stq_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.stq_full); end
        n_tests++; if (bus.stq_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.stq_overflow); end
    endtask

    task automatic test_store_load;
        tick();
        drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 32'h10, 32'h0, 1'b0, 32'h10, 32'h0);
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(1)) begin n_fail++; $display("FAIL st_count1: got %0d want 1", bus.stq_count); end
        n_tests++; if (bus.a_readdataM !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_fwd_a: got %h want deadbeef", bus.a_readdataM); end
        n_tests++; if (bus.b_readdataM !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_fwd_b: got %h want deadbeef", bus.b_readdataM); end
        tick();
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(0)) begin n_fail++; $display("FAIL st_count0: got %0d want 0", bus.stq_count); end
        n_tests++; if (bus.a_readdataM !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_array_a: got %h want deadbeef", bus.a_readdataM); end
        n_tests++; if (bus.b_readdataM !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_array_b: got %h want deadbeef", bus.b_readdataM); end
    endtask

    task automatic test_same_cycle_fwd;
        store_and_drain(32'h20, 32'h12345678);
        drive(1'b1, 32'h20, 32'h11111111, 1'b0, 32'h20, 32'h0);
        #1;
        n_tests++; if (bus.b_readdataM !== 32'h11111111) begin n_fail++; $display("FAIL sc_fwd_b: got %h want 11111111", bus.b_readdataM); end
        n_tests++; if (bus.a_readdataM !== 32'h12345678) begin n_fail++; $display("FAIL sc_old_a: got %h want 12345678", bus.a_readdataM); end
        tick();
        drive(1'b0, 32'h20, 32'h0, 1'b0, 32'h20, 32'h0);
        #1;
        n_tests++; if (bus.a_readdataM !== 32'h11111111) begin n_fail++; $display("FAIL sc_queue_a: got %h want 11111111", bus.a_readdataM); end
        tick();
    endtask

    task automatic test_same_word_both;
        // Lane b address carries offset and high bits that must alias to word 8.
        drive(1'b1, 32'h20, 32'hAAAA0000, 1'b1, 32'h0000_0423, 32'hBBBB0000);
        #1;
        n_tests++; if (bus.b_readdataM !== 32'hAAAA0000) begin n_fail++; $display("FAIL sw_b_sees_a: got %h want aaaa0000", bus.b_readdataM); end
        n_tests++; if (bus.a_readdataM !== 32'h11111111) begin n_fail++; $display("FAIL sw_a_old: got %h want 11111111", bus.a_readdataM); end
        tick();
        drive(1'b0, 32'h20, 32'h0, 1'b0, 32'h20, 32'h0);
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(2)) begin n_fail++; $display("FAIL sw_count2: got %0d want 2", bus.stq_count); end
        n_tests++; if (bus.a_readdataM !== 32'hBBBB0000) begin n_fail++; $display("FAIL sw_q2_a: got %h want bbbb0000", bus.a_readdataM); end
        n_tests++; if (bus.b_readdataM !== 32'hBBBB0000) begin n_fail++; $display("FAIL sw_q2_b: got %h want bbbb0000", bus.b_readdataM); end
        tick();
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(1)) begin n_fail++; $display("FAIL sw_count1: got %0d want 1", bus.stq_count); end
        n_tests++; if (bus.a_readdataM !== 32'hBBBB0000) begin n_fail++; $display("FAIL sw_q1_a: got %h want bbbb0000", bus.a_readdataM); end
        tick();
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(0)) begin n_fail++; $display("FAIL sw_count0: got %0d want 0", bus.stq_count); end
        n_tests++; if (bus.a_readdataM !== 32'hBBBB0000) begin n_fail++; $display("FAIL sw_array_a: got %h want bbbb0000", bus.a_readdataM); end
    endtask

    task automatic test_overflow_no_stall;
        int          exp_cnt  [4] = '{2, 3, 4, 4};
        logic        exp_full [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        exp_ovf  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] a_addr;
        store_and_drain(32'h1C, 32'hCAFEF00D);
        for (int c = 0; c < 4; c++) begin
            a_addr = 32'(8 * c);
            drive(1'b1, a_addr, 32'h5000_0000 + 32'(2 * c),
                  1'b1, a_addr + 32'h4, 32'h5000_0001 + 32'(2 * c));
            tick();
            #1;
            n_tests++; if (bus.stq_count !== CNT_W'(exp_cnt[c])) begin n_fail++; $display("FAIL ov_count[%0d]: got %0d want %0d", c, bus.stq_count, exp_cnt[c]); end
            n_tests++; if (bus.stq_full !== exp_full[c]) begin n_fail++; $display("FAIL ov_full[%0d]: got %b want %b", c, bus.stq_full, exp_full[c]); end
            n_tests++; if (bus.stq_overflow !== exp_ovf[c]) begin n_fail++; $display("FAIL ov_flag[%0d]: got %b want %b", c, bus.stq_overflow, exp_ovf[c]); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_empty("ov");
        drive(1'b0, 32'h18, 32'h0, 1'b0, 32'h1C, 32'h0);
        #1;
        n_tests++; if (bus.stq_overflow !== 1'b1) begin n_fail++; $display("FAIL ov_sticky: got %b want 1", bus.stq_overflow); end
        n_tests++; if (bus.a_readdataM !== 32'h5000_0006) begin n_fail++; $display("FAIL ov_last_a: got %h want 50000006", bus.a_readdataM); end
        n_tests++; if (bus.b_readdataM !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ov_dropped_b: got %h want cafef00d", bus.b_readdataM); end
        tick();
    endtask

    task automatic test_reset_mid_drain;
        drive(1'b1, 32'h84, 32'h1000_0084, 1'b1, 32'h88, 32'h1000_0088);
        tick();
        drive(1'b1, 32'h8C, 32'h1000_008C, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_empty("rst_pre");
        drive(1'b1, 32'h80, 32'hBAD0_0080, 1'b1, 32'h84, 32'hBAD0_0084);
        tick();
        drive(1'b1, 32'h88, 32'hBAD0_0088, 1'b1, 32'h8C, 32'hBAD0_008C);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(3)) begin n_fail++; $display("FAIL rm_pending: got %0d want 3", bus.stq_count); end
        #1 rst = 1'b0;
        #1;
        n_tests++; if (bus.stq_count !== CNT_W'(0)) begin n_fail++; $display("FAIL rm_count: got %0d want 0", bus.stq_count); end
        n_tests++; if (bus.stq_full !== 1'b0) begin n_fail++; $display("FAIL rm_full: got %b want 0", bus.stq_full); end
        n_tests++; if (bus.stq_overflow !== 1'b0) begin n_fail++; $display("FAIL rm_overflow: got %b want 0", bus.stq_overflow); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        drive(1'b0, 32'h80, 32'h0, 1'b0, 32'h84, 32'h0);
        #1;
        n_tests++; if (bus.a_readdataM !== 32'hBAD0_0080) begin n_fail++; $display("FAIL rm_drained: got %h want bad00080", bus.a_readdataM); end
        n_tests++; if (bus.b_readdataM !== 32'h1000_0084) begin n_fail++; $display("FAIL rm_keep84: got %h want 10000084", bus.b_readdataM); end
        drive(1'b0, 32'h88, 32'h0, 1'b0, 32'h8C, 32'h0);
        #1;
        n_tests++; if (bus.a_readdataM !== 32'h1000_0088) begin n_fail++; $display("FAIL rm_keep88: got %h want 10000088", bus.a_readdataM); end
        n_tests++; if (bus.b_readdataM !== 32'h1000_008C) begin n_fail++; $display("FAIL rm_keep8c: got %h want 1000008c", bus.b_readdataM); end
        tick();
    endtask

    task automatic test_stall_wrap;
        int          sent = 0;
        int          cyc  = 0;
        logic [31:0] ea;
        logic [31:0] eb;
        while (sent < 16 && cyc < 200) begin
            if (!bus.stq_full) begin
                drive(1'b1, 32'h100 + 32'(4 * sent), 32'h7000_0000 + 32'(sent),
                      1'b1, 32'h104 + 32'(4 * sent), 32'h7000_0001 + 32'(sent));
                sent += 2;
            end else begin
                drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
            end
            tick();
            cyc++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        n_tests++; if (sent != 16) begin n_fail++; $display("FAIL sw_issue_timeout: sent %0d want 16", sent); end
        wait_empty("stall");
        n_tests++; if (bus.stq_overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow: got %b want 0", bus.stq_overflow); end
        for (int k = 0; k < 16; k += 2) begin
            ea = 32'h7000_0000 + 32'(k);
            eb = 32'h7000_0001 + 32'(k);
            drive(1'b0, 32'h100 + 32'(4 * k), 32'h0, 1'b0, 32'h104 + 32'(4 * k), 32'h0);
            #1;
            n_tests++; if (bus.a_readdataM !== ea) begin n_fail++; $display("FAIL stall_word[%0d]: got %h want %h", k, bus.a_readdataM, ea); end
            n_tests++; if (bus.b_readdataM !== eb) begin n_fail++; $display("FAIL stall_word[%0d]: got %h want %h", k + 1, bus.b_readdataM, eb); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_same_cycle_fwd();
        test_same_word_both();
        test_overflow_no_stall();
        test_reset_mid_drain();
        test_stall_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_dmem_stq.md
Name: dual_dmem_stq

Overview:
Data-memory stage for the dual-issue pipeline. It accepts two memory-stage accesses per cycle, one per lane, and returns combinational read data for each lane. Stores go into a small in-order store queue, which drains one entry per cycle into a single-write-port word array. Loads see pending queued stores through forwarding. The stq_full output lets the hazard logic stall fetch/decode before the queue overflows.

Parameters:
ADDR_W, 8, word-address bits; the array holds 2^ADDR_W 32-bit words.
STQ_DEPTH, 4, number of store-queue entries; a power of two, minimum 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
a_memwriteM  in  1  lane-a store request (older instruction)
a_aluoutM  in  32  lane-a byte address
a_writedataM  in  32  lane-a store data
b_memwriteM  in  1  lane-b store request (younger instruction)
b_aluoutM  in  32  lane-b byte address
b_writedataM  in  32  lane-b store data
a_readdataM  out  32  lane-a load data, combinational
b_readdataM  out  32  lane-b load data, combinational
stq_full  out  1  fewer than 2 free entries
stq_count  out  $clog2(STQ_DEPTH)+1  occupied entries
stq_overflow  out  1  sticky: a store was dropped

Behaviour:
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - addr[1:0] and the bits above ADDR_W+1 are ignored.
  - Word stores only.
- Reset (rst=0, asynchronous):
  - Queue is emptied: head, tail and count = 0; stq_full = 0; stq_overflow = 0.
  - The memory array is not reset.
  - Pending queued stores are discarded, including on reset mid-drain.
- Queue:
  - Circular buffer with head/tail pointers that wrap modulo STQ_DEPTH.
  - Each entry holds {valid, word index, data}.
- Enqueue, on the rising edge:
  - If a_memwriteM, lane a is written at tail.
  - Then, if b_memwriteM, lane b is written at the next slot.
  - Program order is a before b. Zero, one or two entries per cycle.
- Drain, on the same edge:
  - If count>0, the head entry is written to the array and head advances.
  - Drain capacity frees before enqueue: a full queue with one drain accepts one new store.
- Count update: count_next = count - drain + accepted_stores.
- Overflow:
  - A store that does not fit after drain is dropped; lane b drops first.
  - Any drop sets stq_overflow until reset.
  - Under correct stalling on stq_full, overflow never occurs.
- stq_full = (count > STQ_DEPTH-2). Registered-state derived, so no combinational path from the store inputs.
- Load data for lane a, combinational, priority highest first:
  1. Youngest valid queue entry matching the word index.
  2. Array contents.
  - Lane a never sees lane b's same-cycle store.
- Load data for lane b, priority highest first:
  1. a_writedataM, if a_memwriteM and the word indices match (same-cycle forward, lane a older).
  2. Youngest matching valid queue entry.
  3. Array.
- Same-cycle stores to the same word from both lanes: both are enqueued; after drain the array holds the lane-b data.
- Read-during-drain: the draining entry is still valid in the queue that cycle, so forwarding covers it. There is no array read/write hazard.
- Latency:
  - Stores become array-visible 1 + queue-position cycles after issue.
  - Load data is zero-latency, in the same cycle.
- Load data is driven regardless of memwrite; the consumer selects it with memtoreg.

Test Plan:
- Reset then idle → stq_count=0, stq_full=0, stq_overflow=0; a load of any address returns array contents.
- Lane-a store addr 0x10, data 0xDEADBEEF; next cycle, load addr 0x10 on both lanes → 0xDEADBEEF (from queue or array); after 2 cycles stq_count=0 and the array word 4 holds 0xDEADBEEF.
- Same cycle: a stores 0x20←0x11111111 and b loads 0x20 → b_readdataM=0x11111111 that cycle; a_readdataM returns the old array value.
- Both lanes store word 8 (a=0xAAAA0000, b=0xBBBB0000) → stq_count=2 next cycle; after drain, a load of 0x20 returns 0xBBBB0000 throughout.
- Issue dual stores to distinct addresses 0x0, 0x4, 0x8, ... on every cycle with no stall, STQ_DEPTH=4 → stq_full rises at count≥3, and lane-b stores are dropped with stq_overflow=1. Repeat with the stimulus held off while stq_full=1 → no overflow, and all stores reach the array in order, with head/tail wrapping at least twice.
- Assert rst low with 3 entries pending → queue empties immediately; stq_count=0; the pending data never reaches the array.
